// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexes a 16-bit BCD word {digit3..digit0} onto a common-anode
// 4-digit seven-segment display (active-low anodes, cathodes and decimal
// point). The BCD word and decimal-point mask are snapshotted once per frame
// so a frame is never torn by mid-frame input changes. Enable and blink gate
// the anodes only; all counters keep running.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (3..1) are blanked (cathodes all off)
//   undefined -> every digit is decoded, leading zeros are shown as '0'
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLINK_HZ   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] segments_in,
    input  logic [3:0]  dp_mask,
    input  logic        enable,
    input  logic        blink,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  an_out,
    output logic        frame_done
);

    localparam int DIGIT_TICK = CLOCK_FREQ / REFRESH_HZ;
    localparam int BLINK_TICK = CLOCK_FREQ / (2 * BLINK_HZ);
    localparam int PSC_W      = (DIGIT_TICK > 1) ? $clog2(DIGIT_TICK) : 1;
    localparam int BLK_W      = (BLINK_TICK > 1) ? $clog2(BLINK_TICK) : 1;

    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIGIT_TICK - 1);
    localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);
    localparam logic [PSC_W-1:0] PSC_ZERO = PSC_W'(0);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICK - 1);
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
    localparam logic [BLK_W-1:0] BLK_ZERO = BLK_W'(0);

    // BCD to active-low {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

    logic [PSC_W-1:0] psc_r;
    logic [1:0]       idx_r;
    logic [15:0]      snap_seg_r;
    logic [3:0]       snap_dp_r;
    logic [BLK_W-1:0] blk_cnt_r;
    logic             phase_r;
    logic             first_r;

    logic             tick_s;
    logic             snap_s;
    logic             visible_s;
    logic             lz_blank_s;
    logic [3:0]       nibble_s;
    logic [6:0]       seg_next_s;
    logic [3:0]       an_next_s;
    logic             dp_next_s;

    // Frame-level strobes: digit dwell expiry and snapshot instant.
    always_comb begin
        tick_s = (psc_r == PSC_LAST);
        snap_s = first_r | (tick_s & (idx_r == 2'd3));
    end

    // Select the current digit's nibble and decide leading-zero blanking.
    always_comb begin
        nibble_s   = 4'h0;
        lz_blank_s = 1'b0;
        case (idx_r)
            2'd0:    nibble_s = snap_seg_r[3:0];
            2'd1:    nibble_s = snap_seg_r[7:4];
            2'd2:    nibble_s = snap_seg_r[11:8];
            2'd3:    nibble_s = snap_seg_r[15:12];
            default: nibble_s = 4'h0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_r)
            2'd3:    lz_blank_s = (snap_seg_r[15:12] == 4'h0);
            2'd2:    lz_blank_s = (snap_seg_r[15:8]  == 8'h00);
            2'd1:    lz_blank_s = (snap_seg_r[15:4]  == 12'h000);
            default: lz_blank_s = 1'b0;
        endcase
`else
        lz_blank_s = 1'b0;
`endif
    end

    // Next values for the registered display outputs.
    always_comb begin
        visible_s = enable & ~(blink & phase_r);
        if (lz_blank_s) begin
            seg_next_s = 7'h7F;
        end else begin
            seg_next_s = seg7_decode(nibble_s);
        end
        if (visible_s) begin
            an_next_s = ~(4'b0001 << idx_r);
        end else begin
            an_next_s = 4'b1111;
        end
        dp_next_s = ~snap_dp_r[idx_r];
    end

    // Post-reset marker: the first running cycle acts as a frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_r <= 1'b1;
        end else begin
            first_r <= 1'b0;
        end
    end

    // Digit dwell prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_r <= PSC_ZERO;
            idx_r <= 2'd0;
        end else if (first_r) begin
            psc_r <= PSC_ZERO;
            idx_r <= 2'd0;
        end else if (tick_s) begin
            psc_r <= PSC_ZERO;
            idx_r <= idx_r + 2'd1;
        end else begin
            psc_r <= psc_r + PSC_ONE;
            idx_r <= idx_r;
        end
    end

    // Tear-free snapshot of the BCD word and decimal-point mask, plus frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_seg_r <= 16'h0000;
            snap_dp_r  <= 4'h0;
            frame_done <= 1'b0;
        end else if (snap_s) begin
            snap_seg_r <= segments_in;
            snap_dp_r  <= dp_mask;
            frame_done <= 1'b1;
        end else begin
            snap_seg_r <= snap_seg_r;
            snap_dp_r  <= snap_dp_r;
            frame_done <= 1'b0;
        end
    end

    // Free-running blink phase generator.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt_r <= BLK_ZERO;
            phase_r   <= 1'b0;
        end else if (blk_cnt_r == BLK_LAST) begin
            blk_cnt_r <= BLK_ZERO;
            phase_r   <= ~phase_r;
        end else begin
            blk_cnt_r <= blk_cnt_r + BLK_ONE;
            phase_r   <= phase_r;
        end
    end

    // Registered display drive; dark until the first snapshot is in place.
    always_ff @(posedge clk) begin
        if (reset || first_r) begin
            an_out  <= 4'b1111;
            seg_out <= 7'h7F;
            dp_out  <= 1'b1;
        end else begin
            an_out  <= an_next_s;
            seg_out <= seg_next_s;
            dp_out  <= dp_next_s;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// Testbench for seven_seg_scan_driver (CLOCK_FREQ=16, REFRESH_HZ=4, BLINK_HZ=1).
// The reference model tracks time as a cycle count since reset release and
// derives digit index, blink phase and snapshot instants arithmetically.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int CF    = 16;
    localparam int RHZ   = 4;
    localparam int BHZ   = 1;
    localparam int DWELL = CF / RHZ;          // 4 cycles per digit
    localparam int FRAME = 4 * DWELL;         // 16 cycles per frame
    localparam int HALFB = CF / (2 * BHZ);    // 8 cycles per blink phase

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] segments_in;
    logic [3:0]  dp_mask;
    logic        enable;
    logic        blink;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .CLOCK_FREQ(CF),
        .REFRESH_HZ(RHZ),
        .BLINK_HZ  (BHZ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .segments_in(segments_in),
        .dp_mask    (dp_mask),
        .enable     (enable),
        .blink      (blink),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state
    int          t = 0;               // running edges since reset release
    logic [15:0] m_seg = 16'h0000;
    logic [3:0]  m_dp  = 4'h0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    logic [6:0] dec_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    // Advance the reference model by one rising edge using the current inputs.
    task automatic model_edge();
        int          idx;
        int          ph;
        logic        vis;
        logic [3:0]  one_hot;
        logic [15:0] upper;
        if (reset) begin
            t     = 0;
            m_seg = 16'h0000;
            m_dp  = 4'h0;
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_fd  = 1'b0;
        end else begin
            t++;
            if (t == 1) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                idx     = ((t - 2) / DWELL) % 4;
                ph      = ((t - 1) / HALFB) % 2;
                vis     = enable && !(blink && (ph == 1));
                one_hot = 4'b0001 << idx;
                e_an    = vis ? ~one_hot : 4'hF;
                upper   = m_seg >> (4 * idx);
                e_seg   = dec_lut[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
                if (idx > 0 && upper == 16'h0000) e_seg = 7'h7F;
`endif
                e_dp    = ~m_dp[idx];
            end
            e_fd = ((t - 1) % FRAME) == 0;
            if (e_fd) begin
                m_seg = segments_in;
                m_dp  = dp_mask;
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, model the rising edge, check just after.
    task automatic step(input logic rst, input logic [15:0] seg, input logic [3:0] dp,
                        input logic en, input logic bl);
        @(negedge clk);
        reset       = rst;
        segments_in = seg;
        dp_mask     = dp;
        enable      = en;
        blink       = bl;
        @(posedge clk);
        model_edge();
        #1;
        check_val("an_out",     {12'h000, an_out},       {12'h000, e_an});
        check_val("seg_out",    {9'h000, seg_out},       {9'h000, e_seg});
        check_val("dp_out",     {15'h0000, dp_out},      {15'h0000, e_dp});
        check_val("frame_done", {15'h0000, frame_done},  {15'h0000, e_fd});
    endtask

    initial begin
        logic [15:0] r_seg;
        logic [3:0]  r_dp;
        logic        r_en;
        logic        r_bl;
        logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

        reset       = 1'b1;
        segments_in = 16'h0000;
        dp_mask     = 4'h0;
        enable      = 1'b0;
        blink       = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) step(1'b1, 16'h1234, 4'h0, 1'b1, 1'b0);

        // Plain scan of 1234
        for (int i = 0; i < 40; i++) step(1'b0, 16'h1234, 4'h0, 1'b1, 1'b0);
        // Mid-frame change to 5678
        for (int i = 0; i < 40; i++) step(1'b0, 16'h5678, 4'h0, 1'b1, 1'b0);
        // Invalid BCD nibble and decimal point on digit 2
        for (int i = 0; i < 40; i++) step(1'b0, 16'h00A9, 4'b0100, 1'b1, 1'b0);
        // Leading zero patterns
        for (int i = 0; i < 36; i++) step(1'b0, 16'h0105, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 36; i++) step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
        // Display disabled, then blinking
        for (int i = 0; i < 20; i++) step(1'b0, 16'h4321, 4'h9, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 16'h4321, 4'h9, 1'b1, 1'b1);
        // Reset in the middle of a frame
        for (int i = 0; i < 7; i++)  step(1'b0, 16'h9876, 4'h3, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)  step(1'b1, 16'h9876, 4'h3, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b0, 16'h9876, 4'h3, 1'b1, 1'b0);

        // Randomized traffic
        r_seg = 16'h1234;
        r_dp  = 4'h0;
        r_en  = 1'b1;
        r_bl  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r_seg = 16'($urandom) & masks[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0) r_dp = 4'($urandom);
            if ($urandom_range(0, 31) == 0) r_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) r_bl = ~r_bl;
            step(($urandom_range(0, 299) == 0), r_seg, r_dp, r_en, r_bl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
